// File: rtl/add_sub_arb.sv
// ---------------------------------------------------------------------------
// add_sub_arb
// Shares one combinational add_sub unit among NUM_REQ requesters. Grants one
// op at a time over valid/ready, drives registered operands to the add_sub,
// captures sum/carry one cycle later and returns a tagged response.
//
// Build option:
//   ADD_SUB_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                              undefined -> round-robin (default)
// ---------------------------------------------------------------------------
module add_sub_arb #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_b,
    input  logic [NUM_REQ-1:0]         i_req_s,
    output logic [WIDTH-1:0]           o_as_a,
    output logic [WIDTH-1:0]           o_as_b,
    output logic                       o_as_s,
    input  logic [WIDTH-1:0]           i_as_sum,
    input  logic                       i_as_cout,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [IDW-1:0]             o_rsp_id,
    output logic [WIDTH-1:0]           o_rsp_sum,
    output logic                       o_rsp_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q;
    state_t         next_state;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] grant;
    logic           grant_vld;
    int unsigned    idx;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Grant search (first valid after pointer, wrapping), ready and next state
    always_comb begin
        next_state  = state_q;
        grant       = '0;
        grant_vld   = 1'b0;
        idx         = 0;
        o_req_ready = '0;

        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = (32'(ptr_q) + off) % NUM_REQ;
            if (!grant_vld && i_req_valid[IDW'(idx)]) begin
                grant     = IDW'(idx);
                grant_vld = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    next_state = EXEC;
                    if (i_rst_n) begin
                        o_req_ready[grant] = 1'b1;
                    end
                end
            end
            EXEC: begin
                next_state = RESP;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand latch on accept, result capture after the add_sub has settled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_as_a      <= '0;
            o_as_b      <= '0;
            o_as_s      <= 1'b0;
            id_q        <= '0;
            ptr_q       <= IDW'(NUM_REQ - 1);
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= '0;
            o_rsp_sum   <= '0;
            o_rsp_cout  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        o_as_a <= i_req_a[grant*WIDTH +: WIDTH];
                        o_as_b <= i_req_b[grant*WIDTH +: WIDTH];
                        o_as_s <= i_req_s[grant];
                        id_q   <= grant;
`ifndef ADD_SUB_ARB_FIXED_PRIO_EN
                        ptr_q  <= grant;
`endif
                    end
                end
                EXEC: begin
                    o_rsp_sum   <= i_as_sum;
                    o_rsp_cout  <= i_as_cout;
                    o_rsp_id    <= id_q;
                    o_rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    o_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_sub_arb.sv
// ---------------------------------------------------------------------------
// tb_add_sub_arb
// Directed and random checks of add_sub_arb with a behavioural add_sub in the
// loop. Expected responses are queued at issue time and popped by a monitor
// on each response handshake.
// ---------------------------------------------------------------------------
module tb_add_sub_arb;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned IDW     = 1;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } rsp_t;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_s;
    logic [WIDTH-1:0]         as_a;
    logic [WIDTH-1:0]         as_b;
    logic                     as_s;
    logic [WIDTH-1:0]         as_sum;
    logic                     as_cout;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_cout;

    rsp_t exp_q[$];
    int   grant_log[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_push   = 0;
    int   n_rsp    = 0;
    int   accepts  = 0;
    bit   hold     = 1'b0;
    int   m_ptr;
    int   added;
    int   mark;
    logic [WIDTH-1:0] op_a [NUM_REQ];
    logic [WIDTH-1:0] op_b [NUM_REQ];
    logic             op_s [NUM_REQ];

    always #5 clk = ~clk;

    // Behavioural add_sub: subtraction as a + ~b + 1
    assign {as_cout, as_sum} = as_s ? ({1'b0, as_a} + {1'b0, ~as_b} + 5'd1)
                                    : ({1'b0, as_a} + {1'b0, as_b});

    add_sub_arb #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .i_req_s     (req_s),
        .o_as_a      (as_a),
        .o_as_b      (as_b),
        .o_as_s      (as_s),
        .i_as_sum    (as_sum),
        .i_as_cout   (as_cout),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_id    (rsp_id),
        .o_rsp_sum   (rsp_sum),
        .o_rsp_cout  (rsp_cout)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Integer reference for WIDTH=4 add/sub
    task automatic push_exp(input int id, input int a, input int b, input int s);
        rsp_t e;
        int   r;
        e.id = IDW'(id);
        if (s == 0) begin
            r      = a + b;
            e.sum  = WIDTH'(r % 16);
            e.cout = (r > 15);
        end else begin
            e.sum  = WIDTH'((a - b + 16) % 16);
            e.cout = (a >= b);
        end
        exp_q.push_back(e);
        n_push++;
    endtask

    task automatic set_req(input int k, input int a, input int b, input int s);
        req_a[k*WIDTH +: WIDTH] = WIDTH'(a);
        req_b[k*WIDTH +: WIDTH] = WIDTH'(b);
        req_s[k]                = 1'(s);
        req_valid[k]            = 1'b1;
    endtask

    // Returns on the posedge where the n-th accept takes place
    task automatic wait_accepts(input int n);
        int t;
        t = 0;
        while (accepts < n && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (accepts < n) check("accept_timeout", accepts, n);
    endtask

    task automatic drain(input bit rnd);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || rsp_valid) && t < 300) begin
            @(posedge clk);
            #2;
            if (rnd) rsp_ready = 1'($urandom_range(0, 1));
            t++;
        end
        rsp_ready = 1'b1;
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] m, input int p);
        for (int o = 1; o <= NUM_REQ; o++) begin
            int i = (p + o) % NUM_REQ;
            if (m[i]) return i;
        end
        return 0;
    endfunction

    // Accept tracker: log grants, drop the winner's valid after its accept edge
    always @(negedge clk) begin : tracker
        logic [NUM_REQ-1:0] acc;
        acc = req_valid & req_ready;
        if (rst_n && acc != '0) begin
            accepts++;
            check("ready_onehot", $countones(acc), 1);
            for (int k = 0; k < NUM_REQ; k++) if (acc[k]) grant_log.push_back(k);
            if (!hold) begin
                @(posedge clk);
                #1;
                req_valid = req_valid & ~acc;
            end
        end
    end

    // Response monitor: compare on every handshake
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_id",   int'(rsp_id),   int'(e.id));
                check("rsp_sum",  int'(rsp_sum),  int'(e.sum));
                check("rsp_cout", int'(rsp_cout), int'(e.cout));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_s     = '0;
        rsp_ready = 1'b0;

        // Reset values, ready blocked while reset is low
        repeat (2) @(posedge clk);
        #2;
        check("rst_ready",     int'(req_ready), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_as_a",      int'(as_a), 0);
        check("rst_as_b",      int'(as_b), 0);
        check("rst_as_s",      int'(as_s), 0);
        check("rst_rsp_id",    int'(rsp_id), 0);
        check("rst_rsp_sum",   int'(rsp_sum), 0);
        check("rst_rsp_cout",  int'(rsp_cout), 0);
        req_valid = '0;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #2;

        // 1) single add with latency check
        push_exp(0, 3, 5, 0);
        set_req(0, 3, 5, 0);
        #1;
        check("t1_ready_comb", int'(req_ready), 1);
        wait_accepts(accepts + 1);
        @(negedge clk);
        check("t1_exec_rsp_valid", int'(rsp_valid), 0);
        check("t1_exec_ready",     int'(req_ready), 0);
        check("t1_as_a", int'(as_a), 3);
        check("t1_as_b", int'(as_b), 5);
        check("t1_as_s", int'(as_s), 0);
        @(negedge clk);
        check("t1_resp_rsp_valid", int'(rsp_valid), 1);
        drain(1'b0);

        // 2) requester 1 add with carry, then subtract with borrow
        push_exp(1, 9, 9, 0);
        set_req(1, 9, 9, 0);
        wait_accepts(accepts + 1);
        drain(1'b0);
        push_exp(1, 5, 7, 1);
        set_req(1, 5, 7, 1);
        wait_accepts(accepts + 1);
        drain(1'b0);

        // 3) both valid continuously
`ifdef ADD_SUB_ARB_FIXED_PRIO_EN
        push_exp(0, 1, 2, 0); push_exp(0, 1, 2, 0);
        push_exp(0, 1, 2, 0); push_exp(0, 1, 2, 0);
`else
        push_exp(0, 1, 2, 0); push_exp(1, 7, 3, 1);
        push_exp(0, 1, 2, 0); push_exp(1, 7, 3, 1);
`endif
        hold = 1'b1;
        mark = grant_log.size();
        set_req(0, 1, 2, 0);
        set_req(1, 7, 3, 1);
        wait_accepts(accepts + 4);
        #2;
        req_valid = '0;
        hold      = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef ADD_SUB_ARB_FIXED_PRIO_EN
            check("t3_grant_order", grant_log[mark + i], 0);
`else
            check("t3_grant_order", grant_log[mark + i], i % 2);
`endif
        end
        drain(1'b0);

        // 4) response back-pressure with new requests pending
        rsp_ready = 1'b0;
        push_exp(0, 15, 1, 0);
        set_req(0, 15, 1, 0);
        wait_accepts(accepts + 1);
        #2;
`ifdef ADD_SUB_ARB_FIXED_PRIO_EN
        push_exp(0, 2, 2, 1);
        push_exp(1, 6, 9, 1);
`else
        push_exp(1, 6, 9, 1);
        push_exp(0, 2, 2, 1);
`endif
        set_req(0, 2, 2, 1);
        set_req(1, 6, 9, 1);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", int'(rsp_valid), 1);
            check("t4_hold_id",    int'(rsp_id), 0);
            check("t4_hold_sum",   int'(rsp_sum), 0);
            check("t4_hold_cout",  int'(rsp_cout), 1);
            check("t4_hold_ready", int'(req_ready), 0);
        end
        @(posedge clk);
        #2;
        rsp_ready = 1'b1;
        drain(1'b0);

        // 5) reset during EXEC aborts the op; then arbitration from reset state
        set_req(0, 5, 5, 0);
        wait_accepts(accepts + 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rsp_valid", int'(rsp_valid), 0);
        check("t5_as_a",      int'(as_a), 0);
        check("t5_as_b",      int'(as_b), 0);
        check("t5_rsp_sum",   int'(rsp_sum), 0);
        check("t5_rsp_id",    int'(rsp_id), 0);
        check("t5_ready",     int'(req_ready), 0);
        req_valid = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("t5_no_rsp_after_reset", int'(rsp_valid), 0);
        push_exp(1, 4, 11, 0);
        set_req(1, 4, 11, 0);
        wait_accepts(accepts + 1);
        check("t5_only_req1", grant_log[$], 1);
        #2;
        drain(1'b0);
        push_exp(0, 8, 8, 0);
        push_exp(1, 0, 1, 1);
        set_req(0, 8, 8, 0);
        set_req(1, 0, 1, 1);
        wait_accepts(accepts + 1);
        check("t5_req0_first", grant_log[$], 0);
        #2;
        drain(1'b0);

        // 6) random ops with random response stalls
        m_ptr = NUM_REQ - 1;
        added = 0;
        for (int round = 0; round < 1000; round++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!req_valid[k] && added < 200 && $urandom_range(0, 1) == 1) begin
                    op_a[k] = WIDTH'($urandom_range(0, 15));
                    op_b[k] = WIDTH'($urandom_range(0, 15));
                    op_s[k] = 1'($urandom_range(0, 1));
                    set_req(k, int'(op_a[k]), int'(op_b[k]), int'(op_s[k]));
                    added++;
                end
            end
            if (req_valid == '0) begin
                if (added >= 200) break;
                continue;
            end
            begin
                int w;
                w = pick(req_valid, m_ptr);
`ifndef ADD_SUB_ARB_FIXED_PRIO_EN
                m_ptr = w;
`endif
                push_exp(w, int'(op_a[w]), int'(op_b[w]), int'(op_s[w]));
                wait_accepts(accepts + 1);
                check("t6_grant", grant_log[$], w);
                #2;
                drain(1'b1);
            end
        end
        check("t6_ops_added", added, 200);
        check("no_lost_or_dup", n_rsp, n_push);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
